// File: rtl/mux_grant_pkg.sv
// Shared definitions for the round-robin grant controller that drives the
// 4-to-1 tri-state bus multiplexer.
//   state_t  : controller FSM states
//   NUM_SRC  : number of bus sources / mux inputs
//   LAST_RST : reset value of the "last owner" pointer, so source 0 wins first
//   onehot4  : select index to one-hot grant vector
package mux_grant_pkg;

  localparam int         NUM_SRC  = 4;
  localparam logic [1:0] LAST_RST = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  function automatic logic [NUM_SRC-1:0] onehot4(input logic [1:0] idx);
    return NUM_SRC'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_grant_if.sv
// Bundle between the grant controller and the bus-mux side.
//   req  : per-source request (source -> controller)
//   sel  : mux select, current or most recent owner
//   en   : mux enable, high only while a grant is active
//   gnt  : one-hot active grant, zero when en is low
//   busy : controller is not idle
//   rel  : one-cycle pulse on the cycle a grant ends
// master = controller side, slave = requester/mux side.
interface mux_grant_if;
  import mux_grant_pkg::*;

  logic [NUM_SRC-1:0] req;
  logic [1:0]         sel;
  logic               en;
  logic [NUM_SRC-1:0] gnt;
  logic               busy;
  logic               rel;

  modport master (input req, output sel, en, gnt, busy, rel);
  modport slave  (output req, input sel, en, gnt, busy, rel);

endinterface

// File: rtl/mux_grant_ctrl_rr_pick4.sv
// Combinational round-robin picker for four requesters.
//   req  : request vector
//   last : index of the previous owner
//   win  : first requester scanning last+1, last+2, last+3, last (mod 4)
//   any  : at least one request is present (win is meaningless otherwise)
module rr_pick4
  import mux_grant_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [1:0]         last,
  output logic [1:0]         win,
  output logic               any
);

  logic [1:0] idx;

  // Scan from the lowest priority upward so the highest-priority hit is
  // the one left in win; no early exit needed.
  always_comb begin
    win = last;
    idx = last;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) win = idx;
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux_grant_ctrl.sv
// Round-robin grant controller for the 4-to-1 tri-state bus mux.
// Gives the bus to one source at a time, limits each ownership to HOLD_MAX
// cycles and inserts one dead cycle (en=0) between owners so no two
// tri-state buffers ever drive together. All outputs are registered.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mux_grant_if master (req in; sel/en/gnt/busy/rel out)
//
// state | meaning
// IDLE  | no owner, en=0, waiting for any request
// GRANT | one source owns the bus, en=1, sel/gnt frozen
// TURN  | single dead cycle after a grant, en=0, sel keeps old owner
module mux_grant_ctrl
  import mux_grant_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_grant_if.master bus
);

  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic               en_q, en_d;
  logic [NUM_SRC-1:0] gnt_q, gnt_d;
  logic               rel_q, rel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         last_q, last_d;

  logic [1:0]         win;
  logic               any;

  rr_pick4 u_pick (
    .req  (bus.req),
    .last (last_q),
    .win  (win),
    .any  (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
      en_q    <= 1'b0;
      gnt_q   <= '0;
      rel_q   <= 1'b0;
      cnt_q   <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      gnt_q   <= gnt_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    en_d    = en_q;
    gnt_d   = gnt_q;
    rel_d   = 1'b0;
    cnt_d   = cnt_q;
    last_d  = last_q;

    case (state_q)
      IDLE: begin
        if (any) begin
          state_d = GRANT;
          sel_d   = win;
          en_d    = 1'b1;
          gnt_d   = onehot4(win);
          cnt_d   = CNT_ONE;
        end
      end

      GRANT: begin
        // Owner loses the bus as soon as it drops its request or its
        // budget is spent; the grant is never re-extended.
        if (!bus.req[sel_q] || cnt_q == HOLD_CNT) begin
          state_d = TURN;
          en_d    = 1'b0;
          gnt_d   = '0;
          rel_d   = 1'b1;
          last_d  = sel_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      TURN: begin
        // last already points at the owner that just finished, so the
        // picker moves on to the next source in round-robin order.
        if (any) begin
          state_d = GRANT;
          sel_d   = win;
          en_d    = 1'b1;
          gnt_d   = onehot4(win);
          cnt_d   = CNT_ONE;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        gnt_d   = '0;
      end
    endcase
  end

  assign bus.sel  = sel_q;
  assign bus.en   = en_q;
  assign bus.gnt  = gnt_q;
  assign bus.rel  = rel_q;
  assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_mux_grant_ctrl.sv
module tb_mux_grant_ctrl;

  typedef struct {
    bit         rst;
    bit         dut;
    logic [3:0] req;
    logic [1:0] sel;
    logic       en;
    logic       busy;
    logic       rel;
  } vec_t;

  typedef struct packed {
    logic [1:0] sel;
    logic       en;
    logic [3:0] gnt;
    logic       busy;
    logic       rel;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;

  int errors = 0;
  int checks = 0;

  vec_t tbl[$];
  obs_t sb[$];

  always #5 clk = ~clk;

  mux_grant_if i8 ();
  mux_grant_if i1 ();

  assign i8.req = req;
  assign i1.req = req;

  mux_grant_ctrl #(.HOLD_MAX(8), .CNT_W(4)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i8)
  );

  mux_grant_ctrl #(.HOLD_MAX(1), .CNT_W(4)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i1)
  );

  function automatic obs_t observe(bit dut);
    obs_t o;
    o.sel  = dut ? i1.sel  : i8.sel;
    o.en   = dut ? i1.en   : i8.en;
    o.gnt  = dut ? i1.gnt  : i8.gnt;
    o.busy = dut ? i1.busy : i8.busy;
    o.rel  = dut ? i1.rel  : i8.rel;
    return o;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_obs(string tag, obs_t a, obs_t x);
    chk({tag, ".sel"},  8'(a.sel),  8'(x.sel));
    chk({tag, ".en"},   8'(a.en),   8'(x.en));
    chk({tag, ".gnt"},  8'(a.gnt),  8'(x.gnt));
    chk({tag, ".busy"}, 8'(a.busy), 8'(x.busy));
    chk({tag, ".rel"},  8'(a.rel),  8'(x.rel));
  endtask

  // Drive req for the coming edge, queue the expected registered outputs,
  // then compare one time unit after the edge.
  task automatic step(string tag, bit dut, logic [3:0] r,
                      logic [1:0] s, logic e, logic b, logic l);
    obs_t x;
    req    = r;
    x.sel  = s;
    x.en   = e;
    x.gnt  = e ? (4'b0001 << s) : 4'b0000;
    x.busy = b;
    x.rel  = l;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk_obs(tag, observe(dut), x);
  endtask

  // Asynchronous reset pulse inside a cycle; outputs must clear at once.
  task automatic do_reset(string tag);
    obs_t z;
    z = '0;
    rst_n = 1'b0;
    #2;
    chk_obs({tag, ".r8"}, observe(1'b0), z);
    chk_obs({tag, ".r1"}, observe(1'b1), z);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic void add(bit rst, bit dut, logic [3:0] r,
                              logic [1:0] s, logic e, logic b, logic l);
    vec_t v;
    v.rst = rst; v.dut = dut; v.req = r;
    v.sel = s; v.en = e; v.busy = b; v.rel = l;
    tbl.push_back(v);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Sole requester 2, HOLD_MAX=8: 8 cycles granted, rel + dead cycle, re-grant.
    add(1, 0, 4'b0100, 2, 1, 1, 0);
    for (int k = 0; k < 7; k++) add(0, 0, 4'b0100, 2, 1, 1, 0);
    add(0, 0, 4'b0100, 2, 0, 1, 1);
    add(0, 0, 4'b0100, 2, 1, 1, 0);

    // All four requesting: order 0,1,2,3,0 with 8-cycle grants.
    add(1, 0, 4'b1111, 0, 1, 1, 0);
    for (int k = 0; k < 7; k++) add(0, 0, 4'b1111, 0, 1, 1, 0);
    add(0, 0, 4'b1111, 0, 0, 1, 1);
    for (int s = 1; s < 4; s++) begin
      for (int k = 0; k < 8; k++) add(0, 0, 4'b1111, 2'(s), 1, 1, 0);
      add(0, 0, 4'b1111, 2'(s), 0, 1, 1);
    end
    add(0, 0, 4'b1111, 0, 1, 1, 0);

    // Source 1 drops after 3 cycles while 3 waits; then everyone leaves.
    add(1, 0, 4'b0010, 1, 1, 1, 0);
    add(0, 0, 4'b1010, 1, 1, 1, 0);
    add(0, 0, 4'b1010, 1, 1, 1, 0);
    add(0, 0, 4'b1000, 1, 0, 1, 1);
    add(0, 0, 4'b1000, 3, 1, 1, 0);
    add(0, 0, 4'b0000, 3, 0, 1, 1);
    add(0, 0, 4'b0000, 3, 0, 0, 0);
    add(0, 0, 4'b0000, 3, 0, 0, 0);

    // HOLD_MAX=1, sources 0 and 1: en 1,0,1,0 with sel alternating.
    add(1, 1, 4'b0011, 0, 1, 1, 0);
    add(0, 1, 4'b0011, 0, 0, 1, 1);
    add(0, 1, 4'b0011, 1, 1, 1, 0);
    add(0, 1, 4'b0011, 1, 0, 1, 1);
    add(0, 1, 4'b0011, 0, 1, 1, 0);
    add(0, 1, 4'b0011, 0, 0, 1, 1);

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("init");

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset($sformatf("v%0d", i));
      step($sformatf("v%0d", i), tbl[i].dut, tbl[i].req,
           tbl[i].sel, tbl[i].en, tbl[i].busy, tbl[i].rel);
    end

    // Reset in the middle of a grant to source 2, held across an edge.
    do_reset("mid");
    step("mid_g1", 0, 4'b0100, 2, 1, 1, 0);
    step("mid_g2", 0, 4'b0100, 2, 1, 1, 0);
    step("mid_g3", 0, 4'b0100, 2, 1, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_async.en",  8'(i8.en),  8'h0);
    chk("mid_async.gnt", 8'(i8.gnt), 8'h0);
    chk("mid_async.rel", 8'(i8.rel), 8'h0);
    @(posedge clk);
    #1;
    chk("mid_hold.rel", 8'(i8.rel), 8'h0);
    chk("mid_hold.en",  8'(i8.en),  8'h0);
    rst_n = 1'b1;
    step("mid_post", 0, 4'b1111, 0, 1, 1, 0);

    // A request that appears and vanishes inside TURN must not be seen.
    do_reset("turn");
    step("turn_g", 1, 4'b0001, 0, 1, 1, 0);
    step("turn_t", 1, 4'b0001, 0, 0, 1, 1);
    req = 4'b0100;
    #3;
    step("turn_idle", 1, 4'b0000, 0, 0, 0, 0);
    step("turn_new",  1, 4'b0100, 2, 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_grant_ctrl.md
Name: mux_grant_ctrl

Overview:
- Round-robin grant controller sitting directly upstream of the 4-to-1 tri-state bus multiplexer.
- Arbitrates four source requests and drives the mux's 2-bit select and enable.
- Guarantees one owner of the tri-state bus at a time, and inserts one dead cycle (en=0) between owners so no two buffers ever drive together.
- Bounds each ownership to HOLD_MAX cycles.

Parameters:
- HOLD_MAX, 8, maximum consecutive cycles one source may hold the bus (legal range 1..15).
- CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-source bus request; req[i] requests mux input i.
- sel  output  2  mux select, index of the current/most recent owner.
- en  output  1  mux enable; 1 only while a grant is active.
- gnt  output  4  one-hot copy of the active grant (all-zero when en=0).
- busy  output  1  1 whenever state is not IDLE.
- rel  output  1  one-cycle pulse on the cycle a grant ends (en falls).

Behaviour:
- Reset (asynchronous assert, synchronous deassert by the next clk edge):
  - sel=2'b00, en=0, gnt=4'b0000, busy=0, rel=0.
  - state=IDLE, cnt=0, last=2'b11, so source 0 has first priority.
- All outputs are registered; no combinational path from req to any output.
- Arbitration function WIN(req,last): the first i with req[i]=1 scanning last+1, last+2, last+3, last, modulo 4.
- States: IDLE, GRANT, TURN.
- IDLE:
  - en=0.
  - At an edge with req!=0: sel<=WIN, en<=1, gnt<=onehot(WIN), cnt<=1, go to GRANT.
  - Latency is one edge: req high before edge N gives en=1 in the cycle after edge N.
- GRANT:
  - en=1; sel and gnt are held constant.
  - At each edge, if req[sel]==0 or cnt==HOLD_MAX: en<=0, gnt<=0, rel<=1, last<=sel, go to TURN.
  - Otherwise cnt<=cnt+1.
- TURN:
  - Exactly one cycle with en=0; sel keeps the old owner value.
  - At the edge: if req!=0, arbitrate with the updated last and enter GRANT as from IDLE; otherwise go to IDLE.
- rel is high only during the first TURN cycle and is cleared at the next edge.
- sel may change only at an edge where en transitions 0→1, never while en=1.
- A requester that drops req for part of its grant loses the bus; a grant is never re-extended.
- A sole requester holding req continuously is re-granted after each TURN cycle, so en pattern is HOLD_MAX high, 1 low, repeating.
- HOLD_MAX=1: every grant lasts exactly one cycle, so en toggles 1,0,1,0 under continuous requests.
- All four requesting: grant order 0,1,2,3,0,...; no source waits more than 3 grant periods plus 3 TURN cycles.
- req changes during TURN are sampled only at the TURN-exit edge.
- Reset asserted mid-grant: en and gnt drop to 0 immediately (asynchronous), with no rel pulse; the next arbitration after reset starts from source 0.
- Counter never exceeds HOLD_MAX; no wrap-around is possible with legal parameters.

Decomposition:
- Shared package mux_grant_pkg holds:
  - the state enum {IDLE, GRANT, TURN};
  - the constant NUM_SRC=4;
  - the constant LAST_RST=2'b11.
- One natural sub-module: rr_pick4, a combinational round-robin picker (inputs req[3:0] and last[1:0]; outputs win[1:0] and any).
- The FSM and counter stay in mux_grant_ctrl.

Test Plan:
- Reset then req=4'b0100 held, HOLD_MAX=8: en rises one edge later with sel=2, gnt=4'b0100; en high 8 cycles; rel=1 for one cycle; en low 1 cycle; re-granted to 2.
- req=4'b1111 held: successive grants sel=0,1,2,3,0, each 8 cycles long, separated by single en=0 cycles; gnt is never multi-hot.
- Grant to source 1, drop req[1] after 3 cycles while req[3]=1: en falls at that edge, one TURN cycle, then sel=3; source 1 held the bus exactly 3 cycles.
- HOLD_MAX=1 with req=4'b0011: en pattern 1,0,1,0; sel alternates 0,1.
- Reset pulse (rst_n=0) mid-GRANT with sel=2: en=0 and gnt=0 immediately, with no rel pulse; after release with req=4'b1111, the first grant goes to sel=0.
- req=0 after a grant ends: TURN → IDLE; busy=0, en stays 0, sel holds its last value.
